// File: rtl/mc8051_opnd_pipe.sv
// Registered ALU operand / memory address selector with valid/ready output and a one-entry skid buffer.
// Optional write-back forwarding into the shadow registers is enabled by defining MC8051_OPND_FWD_EN.
module mc8051_opnd_pipe #(
    parameter int ADDR_W = 16,
    parameter int NUM_SX = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_vld,
    output logic                  o_rdy,
    input  logic [3:0]            i_alu_in0_sel,
    input  logic [3:0]            i_alu_in1_sel,
    input  logic [2:0]            i_alu_incy_sel,
    input  logic [3:0]            i_addr_sel,
    input  logic [7:0]            i_s2_data_buf,
    input  logic [7:0]            i_s3_data_buf,
    input  logic [8*NUM_SX-1:0]   i_sx,
    input  logic [NUM_SX-1:0]     i_sbit,
    input  logic [ADDR_W-1:0]     i_pc,
    input  logic                  i_rs0_q,
    input  logic                  i_rs1_q,
`ifdef MC8051_OPND_FWD_EN
    input  logic                  i_wb_vld,
    input  logic [3:0]            i_wb_sx_idx,
    input  logic [7:0]            i_wb_data,
`endif
    output logic                  o_vld,
    input  logic                  i_rdy,
    output logic [7:0]            o_alu_in0,
    output logic [7:0]            o_alu_in1,
    output logic                  o_alu_in_cy,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic                  o_addr_wrap
);

    localparam int SX1 = (NUM_SX > 1) ? 1 : 0;

    typedef struct packed {
        logic [7:0]        in0;
        logic [7:0]        in1;
        logic              cy;
        logic [ADDR_W-1:0] addr;
        logic              wrap;
    } pay_t;

    logic [8*NUM_SX-1:0] w_sx;
    logic [ADDR_W:0]     w_sum;
    pay_t                w_new;
    pay_t                r_out;
    pay_t                r_skid;
    logic                r_o_vld;
    logic                r_skid_vld;
    logic                r_rdy;
    logic                w_accept;
    logic                w_advance;

    // Shadow registers as seen by every select path, after any same-cycle write-back.
    always_comb begin
        w_sx = i_sx;
`ifdef MC8051_OPND_FWD_EN
        for (int k = 0; k < NUM_SX; k++) begin
            if (i_wb_vld && (i_wb_sx_idx == 4'(k)))
                w_sx[8*k +: 8] = i_wb_data;
        end
`endif
    end

    function automatic logic [7:0] f_opnd(input logic [3:0] sel, input logic [8*NUM_SX-1:0] sx);
        logic [7:0] r;
        r = 8'h00;
        case (sel)
            4'h0: r = i_s2_data_buf;
            4'h1: r = i_s3_data_buf;
            4'h2: r = i_pc[7:0];
            4'h3: r = i_pc[15:8];
            4'hE: r = 8'h01;
            4'hF: r = 8'hFF;
            default: begin
                for (int k = 0; k < NUM_SX; k++) begin
                    if (sel == 4'(k + 4))
                        r = sx[8*k +: 8];
                end
            end
        endcase
        return r;
    endfunction

    // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_new.in0  = f_opnd(i_alu_in0_sel, w_sx);
        w_new.in1  = f_opnd(i_alu_in1_sel, w_sx);
        w_new.cy   = 1'b0;
        w_new.addr = '0;
        w_new.wrap = 1'b0;
        w_sum      = '0;

        if (i_alu_incy_sel == 3'd6)
            w_new.cy = 1'b1;
        for (int k = 0; k < NUM_SX; k++) begin
            if (k < 8 && i_alu_incy_sel == 3'(k))
                w_new.cy = i_sbit[k];
        end

        case (i_addr_sel)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7:
                w_new.addr = ADDR_W'({i_rs1_q, i_rs0_q, i_addr_sel[2:0]});
            4'h8: w_new.addr = i_pc;
            4'h9: w_new.addr = ADDR_W'({i_s3_data_buf, i_s2_data_buf});
            4'hA: begin
                w_sum      = (ADDR_W+1)'({i_s3_data_buf, w_sx[7:0]}) + (ADDR_W+1)'(i_s2_data_buf);
                w_new.addr = w_sum[ADDR_W-1:0];
                w_new.wrap = w_sum[ADDR_W];
            end
            4'hB: begin
                w_sum      = {1'b0, i_pc} + (ADDR_W+1)'(i_s2_data_buf);
                w_new.addr = w_sum[ADDR_W-1:0];
                w_new.wrap = w_sum[ADDR_W];
            end
            4'hC: w_new.addr = ADDR_W'(i_s2_data_buf);
            // Bit-addressable space: low half maps into bytes 0x20..0x2F, high half into SFR bytes.
            4'hD: w_new.addr = i_s2_data_buf[7] ? ADDR_W'({i_s2_data_buf[7:3], 3'b000})
                                                : ADDR_W'(8'h20 + {4'b0000, i_s2_data_buf[6:3]});
            4'hE: w_new.addr = ADDR_W'(w_sx[8*SX1 +: 8]);
            default: w_new.addr = '0;
        endcase
    end

    assign w_accept  = i_vld && r_rdy;
    assign w_advance = !r_o_vld || i_rdy;

    // o_rdy is a pure register: it falls only when the skid entry fills, never from i_rdy directly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out      <= '0;
            r_skid     <= '0;
            r_o_vld    <= 1'b0;
            r_skid_vld <= 1'b0;
            r_rdy      <= 1'b1;
        end else if (i_flush) begin
            r_o_vld    <= 1'b0;
            r_skid_vld <= 1'b0;
            r_rdy      <= 1'b1;
        end else if (w_advance) begin
            if (r_skid_vld) begin
                r_out      <= r_skid;
                r_o_vld    <= 1'b1;
                r_skid_vld <= 1'b0;
                r_rdy      <= 1'b1;
            end else if (w_accept) begin
                r_out   <= w_new;
                r_o_vld <= 1'b1;
            end else begin
                r_o_vld <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid     <= w_new;
            r_skid_vld <= 1'b1;
            r_rdy      <= 1'b0;
        end
    end

    assign o_rdy       = r_rdy;
    assign o_vld       = r_o_vld;
    assign o_alu_in0   = r_out.in0;
    assign o_alu_in1   = r_out.in1;
    assign o_alu_in_cy = r_out.cy;
    assign o_mem_addr  = r_out.addr;
    assign o_addr_wrap = r_out.wrap;

endmodule

// File: tb/tb_mc8051_opnd_pipe.sv
// Scoreboard bench for mc8051_opnd_pipe: directed vectors push expected results, a monitor pops on each output transfer.
// Forwarding vectors are included when MC8051_OPND_FWD_EN is defined.
module tb_mc8051_opnd_pipe;

    typedef struct {
        logic [7:0]  in0;
        logic [7:0]  in1;
        logic        cy;
        logic [15:0] addr;
        logic        wrap;
    } exp_t;

    typedef struct {
        logic [3:0]  in0_sel;
        logic [3:0]  in1_sel;
        logic [2:0]  cy_sel;
        logic [3:0]  addr_sel;
        logic [7:0]  s2;
        logic [7:0]  s3;
        logic [15:0] pc;
        logic        rs1;
        logic        rs0;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        vld = 1'b0;
    logic        o_rdy;
    logic [3:0]  in0_sel = '0;
    logic [3:0]  in1_sel = '0;
    logic [2:0]  cy_sel = '0;
    logic [3:0]  addr_sel = '0;
    logic [7:0]  s2 = '0;
    logic [7:0]  s3 = '0;
    logic [31:0] sx = 32'h4433_225A;
    logic [3:0]  sbit = 4'b0101;
    logic [15:0] pc = '0;
    logic        rs0 = 1'b0;
    logic        rs1 = 1'b0;
    logic        o_vld;
    logic        rdy = 1'b1;
    logic [7:0]  o_in0;
    logic [7:0]  o_in1;
    logic        o_cy;
    logic [15:0] o_addr;
    logic        o_wrap;
`ifdef MC8051_OPND_FWD_EN
    logic        wb_vld = 1'b0;
    logic [3:0]  wb_idx = '0;
    logic [7:0]  wb_data = '0;
`endif

    int   n_checks = 0;
    int   n_fail = 0;
    int   n_out = 0;
    exp_t sb[$];
    vec_t vecs[$];

    mc8051_opnd_pipe #(.ADDR_W(16), .NUM_SX(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_vld(vld), .o_rdy(o_rdy),
        .i_alu_in0_sel(in0_sel), .i_alu_in1_sel(in1_sel), .i_alu_incy_sel(cy_sel),
        .i_addr_sel(addr_sel), .i_s2_data_buf(s2), .i_s3_data_buf(s3), .i_sx(sx),
        .i_sbit(sbit), .i_pc(pc), .i_rs0_q(rs0), .i_rs1_q(rs1),
`ifdef MC8051_OPND_FWD_EN
        .i_wb_vld(wb_vld), .i_wb_sx_idx(wb_idx), .i_wb_data(wb_data),
`endif
        .o_vld(o_vld), .i_rdy(rdy), .o_alu_in0(o_in0), .o_alu_in1(o_in1),
        .o_alu_in_cy(o_cy), .o_mem_addr(o_addr), .o_addr_wrap(o_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] i0, input logic [3:0] i1, input logic [2:0] c,
                                input logic [3:0] a, input logic [7:0] v2, input logic [7:0] v3,
                                input logic [15:0] p, input logic r1, input logic r0,
                                input logic [7:0] e0, input logic [7:0] e1, input logic ec,
                                input logic [15:0] ea, input logic ew);
        vec_t v;
        v.in0_sel = i0; v.in1_sel = i1; v.cy_sel = c; v.addr_sel = a;
        v.s2 = v2; v.s3 = v3; v.pc = p; v.rs1 = r1; v.rs0 = r0;
        v.e.in0 = e0; v.e.in1 = e1; v.e.cy = ec; v.e.addr = ea; v.e.wrap = ew;
        return v;
    endfunction

    task automatic drive(input int idx);
        in0_sel  = vecs[idx].in0_sel;
        in1_sel  = vecs[idx].in1_sel;
        cy_sel   = vecs[idx].cy_sel;
        addr_sel = vecs[idx].addr_sel;
        s2       = vecs[idx].s2;
        s3       = vecs[idx].s3;
        pc       = vecs[idx].pc;
        rs1      = vecs[idx].rs1;
        rs0      = vecs[idx].rs0;
        vld      = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the request.
    task automatic send(input int idx);
        int budget;
        drive(idx);
        budget = 0;
        forever begin
            @(negedge clk);
            if (o_rdy) break;
            budget++;
            if (budget > 50) begin
                check("send_timeout", 64'(budget), 64'd0);
                vld = 1'b0;
                return;
            end
        end
        sb.push_back(vecs[idx].e);
        @(posedge clk);
        #1 vld = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && o_vld && rdy) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(o_in0), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("alu_in0", 64'(o_in0), 64'(e.in0));
                check("alu_in1", 64'(o_in1), 64'(e.in1));
                check("alu_in_cy", 64'(o_cy), 64'(e.cy));
                check("mem_addr", 64'(o_addr), 64'(e.addr));
                check("addr_wrap", 64'(o_wrap), 64'(e.wrap));
            end
            n_out++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        //             in0  in1  cy   asel  s2     s3     pc         r1 r0  e_in0  e_in1  cy  addr        wrap
        vecs.push_back(mk(4'h4, 4'hE, 3'd6, 4'hF, 8'h0B, 8'hC7, 16'h1234, 0, 0, 8'h5A, 8'h01, 1, 16'h0000, 0));
        vecs.push_back(mk(4'h0, 4'h1, 3'd0, 4'h5, 8'h0B, 8'hC7, 16'h1234, 1, 0, 8'h0B, 8'hC7, 1, 16'h0015, 0));
        vecs.push_back(mk(4'h2, 4'h3, 3'd1, 4'hD, 8'h0B, 8'hC7, 16'h1234, 0, 0, 8'h34, 8'h12, 0, 16'h0021, 0));
        vecs.push_back(mk(4'h5, 4'h7, 3'd2, 4'hD, 8'hE3, 8'hC7, 16'h1234, 0, 0, 8'h22, 8'h44, 1, 16'h00E0, 0));
        vecs.push_back(mk(4'hF, 4'h8, 3'd7, 4'hB, 8'h20, 8'hC7, 16'hFFF0, 0, 0, 8'hFF, 8'h00, 0, 16'h0010, 1));
        vecs.push_back(mk(4'h3, 4'h6, 3'd3, 4'hA, 8'h0B, 8'hC7, 16'h1234, 0, 0, 8'h12, 8'h33, 0, 16'hC765, 0));
        vecs.push_back(mk(4'h0, 4'h1, 3'd6, 4'hA, 8'hB0, 8'hFF, 16'h1234, 0, 0, 8'hB0, 8'hFF, 1, 16'h000A, 1));
        vecs.push_back(mk(4'hE, 4'hD, 3'd5, 4'h9, 8'h0B, 8'hC7, 16'h1234, 0, 0, 8'h01, 8'h00, 0, 16'hC70B, 0));
        vecs.push_back(mk(4'hE, 4'hD, 3'd5, 4'hE, 8'h0B, 8'hC7, 16'h1234, 0, 0, 8'h01, 8'h00, 0, 16'h0022, 0));
        vecs.push_back(mk(4'hE, 4'hD, 3'd5, 4'h8, 8'h0B, 8'hC7, 16'h1234, 0, 0, 8'h01, 8'h00, 0, 16'h1234, 0));
        vecs.push_back(mk(4'hE, 4'hD, 3'd5, 4'hC, 8'h0B, 8'hC7, 16'h1234, 0, 0, 8'h01, 8'h00, 0, 16'h000B, 0));
        vecs.push_back(mk(4'hE, 4'hD, 3'd5, 4'h2, 8'h0B, 8'hC7, 16'h1234, 0, 1, 8'h01, 8'h00, 0, 16'h000A, 0));
        vecs.push_back(mk(4'h6, 4'hE, 3'd6, 4'hF, 8'h0B, 8'hC7, 16'h1234, 0, 0, 8'h99, 8'h01, 1, 16'h0000, 0));
        vecs.push_back(mk(4'h6, 4'hE, 3'd6, 4'hF, 8'h0B, 8'hC7, 16'h1234, 0, 0, 8'h33, 8'h01, 1, 16'h0000, 0));

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_o_vld", 64'(o_vld), 64'd0);
        check("rst_o_rdy", 64'(o_rdy), 64'd1);
        check("rst_alu_in0", 64'(o_in0), 64'd0);
        check("rst_mem_addr", 64'(o_addr), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming sweep of all select codes with downstream always ready
        for (int i = 0; i < 12; i++) send(i);
        repeat (3) @(posedge clk);
        #1;
        check("sweep_drained", 64'(sb.size()), 64'd0);

        // Back-pressure: A on output, B in skid, C held off until the output drains
        rdy = 1'b0;
        send(0);
        send(1);
        fork
            send(2);
            begin
                @(negedge clk);
                check("stall_o_rdy", 64'(o_rdy), 64'd0);
                check("stall_o_vld", 64'(o_vld), 64'd1);
                check("stall_hold_in0", 64'(o_in0), 64'h5A);
                repeat (3) @(negedge clk);
                check("stall_still_full", 64'(o_rdy), 64'd0);
                check("stall_c_pending", 64'(sb.size()), 64'd2);
                @(posedge clk);
                #1 rdy = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("bp_drained", 64'(sb.size()), 64'd0);

        // Flush with a full skid and a simultaneous request
        rdy = 1'b0;
        send(3);
        send(4);
        drive(5);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        vld   = 1'b0;
        check("flush_o_vld", 64'(o_vld), 64'd0);
        check("flush_o_rdy", 64'(o_rdy), 64'd1);
        check("flush_keeps_data", 64'(o_in0), 64'h22);
        sb.delete();
        rdy = 1'b1;
        n0 = n_out;
        send(6);
        repeat (4) @(posedge clk);
        #1;
        check("flush_single_out", 64'(n_out - n0), 64'd1);

        // Reset in the middle of a stalled transfer
        rdy = 1'b0;
        send(7);
        send(8);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_o_vld", 64'(o_vld), 64'd0);
        check("midrst_o_rdy", 64'(o_rdy), 64'd1);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy = 1'b1;
        n0 = n_out;
        send(9);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_single_out", 64'(n_out - n0), 64'd1);

`ifdef MC8051_OPND_FWD_EN
        wb_vld  = 1'b1;
        wb_idx  = 4'd2;
        wb_data = 8'h99;
        sx[23:16] = 8'h33;
        send(12);
        wb_idx = 4'd12;
        send(13);
        wb_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`endif

        check("final_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc8051_opnd_pipe.md
Name: mc8051_opnd_pipe

Overview:
- Parametrised, registered successor to the core's combinational operand/address selector.
- Captures ALU operand 0/1, carry-in and one generated memory address per accepted request.
- Delivers them to the ALU/memory stage through a valid/ready handshake with a one-entry skid buffer, so the decoder can be back-pressured without losing a request.
- Sits between the instruction decoder (select codes) and the ALU/memory-access stage.

Parameters:
- ADDR_W, 16, memory address width. Legal range 16..24. Upper bits above 16 are zero-filled for concatenated forms.
- NUM_SX, 4, number of 8-bit shadow operand registers and shadow carry bits. Legal range 1..10.

Ports:
- i_clk  in  1  core clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous flush of all buffered requests.
- i_vld  in  1  request valid.
- o_rdy  out  1  request accepted when i_vld && o_rdy.
- i_alu_in0_sel  in  4  operand 0 select.
- i_alu_in1_sel  in  4  operand 1 select.
- i_alu_incy_sel  in  3  carry-in select.
- i_addr_sel  in  4  address select.
- i_s2_data_buf  in  8  stage-2 data buffer.
- i_s3_data_buf  in  8  stage-3 data buffer.
- i_sx  in  8*NUM_SX  shadow registers; sx[k] = i_sx[8k+7:8k].
- i_sbit  in  NUM_SX  shadow carry bits.
- i_pc  in  ADDR_W  program counter.
- i_rs0_q, i_rs1_q  in  1 each  register-bank select.
- o_vld  out  1  output valid.
- i_rdy  in  1  downstream ready.
- o_alu_in0, o_alu_in1  out  8 each  registered operands.
- o_alu_in_cy  out  1  registered carry-in.
- o_mem_addr  out  ADDR_W  registered address.
- o_addr_wrap  out  1  address arithmetic overflowed ADDR_W.

Behaviour:
- Reset (async, i_rst_n=0): o_vld=0, o_rdy=1, all data outputs 0, skid entry empty. Release is synchronous to i_clk.
- Operand select, for both in0 and in1:
  - 0 = s2, 1 = s3, 2 = pc[7:0], 3 = pc[15:8].
  - 4..4+NUM_SX-1 = sx[sel-4].
  - 0xE = 8'h01, 0xF = 8'hFF, any other code = 8'h00.
- Carry-in select: 0..NUM_SX-1 = sbit[sel]; 6 = 1; any other code = 0.
- Address select. R is the bank base = {rs1,rs0,3'b000}.
  - 0..7 = R + sel.
  - 8 = pc.
  - 9 = {s3,s2}.
  - A = {s3,sx[0]} + s2.
  - B = pc + s2.
  - C = {0,s2}.
  - D = bit byte address: s2[7]=0 gives 8'h20 + s2[6:3]; otherwise {s2[7:3],3'b000}.
  - E = {0,sx[min(1,NUM_SX-1)]}.
  - F = 0.
- Address arithmetic and o_addr_wrap:
  - Sums are modulo 2^ADDR_W.
  - o_addr_wrap = carry out of bit ADDR_W-1 for codes A and B; 0 for all other codes.
- Latency and handshake:
  - Latency 1: an accepted request appears on the outputs the next cycle with o_vld=1.
  - Outputs hold stable while o_vld && !i_rdy.
  - Output register advances when !o_vld || i_rdy.
- Skid buffer:
  - If a request is accepted while the output stalls, it goes to the skid entry and o_rdy drops to 0 the next cycle.
  - When the output drains, the skid entry moves to the output and o_rdy returns to 1.
- o_rdy is registered and has no combinational path from i_rdy.
- Simultaneous events:
  - Accept while the output drains and skid is empty: the new request goes straight to the output with no bubble.
  - Flush with i_vld: the flush wins; the request is dropped and o_rdy=1.
- i_flush: next cycle o_vld=0, skid empty, o_rdy=1. Data outputs keep their last values.
- Reset mid-transfer: all buffered requests are discarded immediately.

Optional Feature:
- Macro: MC8051_OPND_FWD_EN.
- Enabled:
  - Adds ports i_wb_vld (1), i_wb_sx_idx (4) and i_wb_data (8).
  - When i_wb_vld=1 and i_wb_sx_idx<NUM_SX, sx[i_wb_sx_idx] is replaced by i_wb_data for every select path in the same cycle, before capture.
- Disabled: the ports are absent and sx is taken only from i_sx.

Test Plan:
- Reset, then i_vld=1 with in0_sel=4, sx[0]=8'h5A, in1_sel=0xE, cy_sel=6, i_rdy=1 -> next cycle o_alu_in0=8'h5A, o_alu_in1=8'h01, o_alu_in_cy=1, o_vld=1.
- rs1=1, rs0=0, addr_sel=5 -> o_mem_addr=16'h0015. Then addr_sel=D with s2=8'h0B -> 16'h0021. Then s2=8'hE3 -> 16'h00E0.
- ADDR_W=16, addr_sel=B, pc=16'hFFF0, s2=8'h20 -> o_mem_addr=16'h0010, o_addr_wrap=1.
- i_rdy=0 with back-to-back requests A,B,C:
  - A is held on the output, B goes to the skid, o_rdy=0, C is not accepted.
  - Raise i_rdy -> A, B, C emerge in order with no loss or duplication.
- Skid full, then i_flush=1 with i_vld=1 -> next cycle o_vld=0, o_rdy=1. Subsequent request D emerges alone.
- With MC8051_OPND_FWD_EN: sx[2]=8'h11, i_wb_vld=1, idx=2, wb_data=8'h99, in0_sel=6 -> o_alu_in0=8'h99. With idx=12 -> 8'h11.
